fifo_arbiter: RTL and testbench

Round-robin scheduler that drains four 6-bit source FIFOs (one per virtual channel) into a shared set of four destination FIFOs. It sits between the input FIFO bank and the output FIFO bank. It issues `pop` to at most one non-empty source per cycle and forwards the returned word as a `push` to the destination selected by the word's two MSBs. It honours downstream `Pausa` back-pressure.

---
 rtl/fifo_arbiter.sv | 139 +++++++++++++
 tb/tb_fifo_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_arbiter.sv
// Round-robin pop scheduler: drains four source FIFOs into four destination FIFOs.
// Define FIFO_ARB_RR_EN for rotating-pointer grant; otherwise the lowest eligible index wins.
module fifo_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [3:0]            Fifo_Empty_in,
  input  logic [3:0]            Pausa_in,
  input  logic [DATA_WIDTH-1:0] Data_in0,
  input  logic [DATA_WIDTH-1:0] Data_in1,
  input  logic [DATA_WIDTH-1:0] Data_in2,
  input  logic [DATA_WIDTH-1:0] Data_in3,
  output logic [3:0]            pop_out,
  output logic [3:0]            push_out,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic [1:0]            State,
  output logic [CNT_WIDTH-1:0]  Word_Count
);

  // state | meaning
  // IDLE  | nothing eligible, no pause with pending data
  // GRANT | a pop was issued this cycle
  // STALL | downstream pause seen while sources hold data
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    STALL = 2'b10
  } state_t;

  state_t                state, state_nxt;
  logic                  armed;
  logic                  vld_q;
  logic                  paused;
  logic                  any_busy;
  logic                  any_elig;
  logic [1:0]            src_q;
  logic [1:0]            src_nxt;
  logic [1:0]            gnt_idx;
  logic [3:0]            elig;
  logic [3:0]            pop_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_sel;

  assign paused   = |Pausa_in;
  assign any_busy = ~&Fifo_Empty_in;
  // pop_out doubles as the re-pop mask: a source's empty flag lags its pop by one cycle
  assign elig     = (armed && !paused) ? (~Fifo_Empty_in & ~pop_out) : 4'b0000;
  assign any_elig = |elig;

`ifdef FIFO_ARB_RR_EN
  logic [1:0] last;
  logic [1:0] rr_idx;

  // walk from last+4 down to last+1 so the nearest index after last is kept
  always_comb begin
    gnt_idx = last;
    rr_idx  = last;
    for (int k = 4; k >= 1; k--) begin
      rr_idx = last + 2'(k);
      if (elig[rr_idx]) gnt_idx = rr_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      last <= 2'd3;
    end else if (any_elig) begin
      last <= gnt_idx;
    end
  end
`else
  always_comb begin
    gnt_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (elig[i]) gnt_idx = 2'(i);
    end
  end
`endif

  assign pop_nxt = any_elig ? (4'b0001 << gnt_idx) : 4'b0000;
  assign src_nxt = {pop_out[3] | pop_out[2], pop_out[3] | pop_out[1]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_elig) state_nxt = GRANT;
        else if (paused && any_busy) state_nxt = STALL;
      end
      GRANT: begin
        if (paused) state_nxt = STALL;
        else if (!any_elig) state_nxt = IDLE;
      end
      STALL: begin
        if (!paused && any_elig) state_nxt = GRANT;
        else state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (src_q)
      2'd0:    data_sel = Data_in0;
      2'd1:    data_sel = Data_in1;
      2'd2:    data_sel = Data_in2;
      default: data_sel = Data_in3;
    endcase
  end

  assign Data_out = vld_q ? data_sel : data_q;
  assign push_out = vld_q ? (4'b0001 << data_sel[DATA_WIDTH-1 -: 2]) : 4'b0000;
  assign State    = state;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state      <= IDLE;
      pop_out    <= 4'b0000;
      armed      <= 1'b0;
      vld_q      <= 1'b0;
      src_q      <= 2'd0;
      data_q     <= '0;
      Word_Count <= '0;
    end else begin
      state   <= state_nxt;
      pop_out <= pop_nxt;
      armed   <= 1'b1;
      vld_q   <= |pop_out;
      src_q   <= src_nxt;
      if (vld_q) begin
        data_q     <= data_sel;
        Word_Count <= Word_Count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed and random stimulus for fifo_arbiter, checked against a cycle-level reference model.
module tb_fifo_arbiter;

  logic       clk;
  logic       reset_L;
  logic [3:0] empty;
  logic [3:0] pausa;
  logic [5:0] d [4];
  logic [3:0] pop_out;
  logic [3:0] push_out;
  logic [5:0] Data_out;
  logic [1:0] State;
  logic [7:0] Word_Count;

  int checks = 0;
  int errors = 0;

  int         m_state;
  int         m_prev;
  int         m_pend;
  bit         m_armed;
  int         m_cnt;
  logic [5:0] m_hold;
`ifdef FIFO_ARB_RR_EN
  int         m_last;
`endif

  fifo_arbiter #(.DATA_WIDTH(6), .CNT_WIDTH(8)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .Fifo_Empty_in(empty),
    .Pausa_in     (pausa),
    .Data_in0     (d[0]),
    .Data_in1     (d[1]),
    .Data_in2     (d[2]),
    .Data_in3     (d[3]),
    .pop_out      (pop_out),
    .push_out     (push_out),
    .Data_out     (Data_out),
    .State        (State),
    .Word_Count   (Word_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset;
    m_state = 0;
    m_prev  = -1;
    m_pend  = -1;
    m_armed = 1'b0;
    m_cnt   = 0;
    m_hold  = 6'd0;
`ifdef FIFO_ARB_RR_EN
    m_last  = 3;
`endif
  endtask

  // advance one clock: predict from the inputs held across the edge, then compare
  task automatic step;
    int         g;
    int         nst;
    bit         paused;
    bit         any_ne;
    bit         el [4];
    logic [5:0] exp_data;
    logic [3:0] exp_push;
    paused = (pausa != 4'b0000);
    any_ne = (empty != 4'b1111);
    for (int i = 0; i < 4; i++)
      el[i] = m_armed && !empty[i] && (m_prev != i) && !paused;
    g = -1;
`ifdef FIFO_ARB_RR_EN
    for (int k = 1; k <= 4; k++)
      if (g < 0 && el[(m_last + k) % 4]) g = (m_last + k) % 4;
`else
    for (int i = 0; i < 4; i++)
      if (g < 0 && el[i]) g = i;
`endif
    case (m_state)
      0:       nst = (g >= 0) ? 1 : ((paused && any_ne) ? 2 : 0);
      1:       nst = paused ? 2 : ((g < 0) ? 0 : 1);
      default: nst = (!paused && g >= 0) ? 1 : 0;
    endcase
    if (m_pend >= 0) begin
      m_cnt  = (m_cnt + 1) % 256;
      m_hold = d[m_pend];
    end
    m_pend  = m_prev;
    m_prev  = g;
`ifdef FIFO_ARB_RR_EN
    if (g >= 0) m_last = g;
`endif
    m_state = nst;
    m_armed = 1'b1;
    @(posedge clk);
    #1;
    exp_data = (m_pend >= 0) ? d[m_pend] : m_hold;
    exp_push = (m_pend >= 0) ? (4'b0001 << exp_data[5:4]) : 4'b0000;
    chk("pop_out", 32'(pop_out), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("push_out", 32'(push_out), 32'(exp_push));
    chk("Data_out", 32'(Data_out), 32'(exp_data));
    chk("State", 32'(State), 32'(m_state));
    chk("Word_Count", 32'(Word_Count), 32'(m_cnt));
  endtask

  initial begin
    reset_L = 1'b0;
    empty   = 4'b1111;
    pausa   = 4'b0000;
    for (int i = 0; i < 4; i++) d[i] = 6'd0;
    model_reset();

    // reset values, then idle with every source empty
    #22;
    chk("rst_pop", 32'(pop_out), 32'd0);
    chk("rst_push", 32'(push_out), 32'd0);
    chk("rst_data", 32'(Data_out), 32'd0);
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_count", 32'(Word_Count), 32'd0);
    reset_L = 1'b1;
    repeat (10) step();
    chk("idle_state", 32'(State), 32'd0);

    // single source drains every other cycle
    empty = 4'b1011;
    d[2]  = 6'b01_0101;
    step();
    chk("single_pop", 32'(pop_out), 32'h4);
    step();
    chk("single_push", 32'(push_out), 32'h2);
    chk("single_data", 32'(Data_out), 32'h15);
    chk("single_gap", 32'(pop_out), 32'd0);
    step();
    chk("single_pop2", 32'(pop_out), 32'h4);
    step();

    // async reset while a word is in flight
    reset_L = 1'b0;
    #1;
    chk("arst_push", 32'(push_out), 32'd0);
    chk("arst_count", 32'(Word_Count), 32'd0);
    chk("arst_pop", 32'(pop_out), 32'd0);
    chk("arst_state", 32'(State), 32'd0);
    model_reset();
    #1;
    reset_L = 1'b1;
    empty   = 4'b1110;
    step();
    chk("release_edge1", 32'(pop_out), 32'd0);
    step();
    chk("release_edge2", 32'(pop_out), 32'h1);

    // all four sources busy, every word targets destination 3
    reset_L = 1'b0;
    #1;
    model_reset();
    #1;
    reset_L = 1'b1;
    empty   = 4'b0000;
    for (int i = 0; i < 4; i++) d[i] = 6'h30 | 6'(i);
    step();
    step();
    for (int s = 3; s <= 11; s++) begin
      step();
      chk("stream_push", 32'(push_out), 32'h8);
    end
    chk("stream_count", 32'(Word_Count), 32'd8);

    // pause mid-stream: pop stops, one trailing push
    pausa = 4'b0001;
    step();
    chk("pause_pop", 32'(pop_out), 32'd0);
    chk("pause_state", 32'(State), 32'h2);
    chk("pause_trail", 32'(push_out), 32'h8);
    step();
    chk("pause_nopush", 32'(push_out), 32'd0);
    repeat (3) step();
    pausa = 4'b0000;
    repeat (6) step();

    // counter wraps after 256 forwarded words
    reset_L = 1'b0;
    #1;
    model_reset();
    #1;
    reset_L = 1'b1;
    empty   = 4'b0000;
    for (int i = 0; i < 4; i++) d[i] = 6'(i * 17);
    repeat (259) step();
    chk("wrap_count", 32'(Word_Count), 32'd0);

    // random traffic with occasional pause
    for (int n = 0; n < 400; n++) begin
      empty = 4'($urandom_range(0, 15));
      pausa = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      for (int i = 0; i < 4; i++) d[i] = 6'($urandom_range(0, 63));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
